present_round_ctrl: RTL and testbench
=====================================

// Module: present_round_ctrl
// PURPOSE
//  Round controller for the masked PRESENT core. Sequences load, rounds and finalisation.
//  Drives the sel line of every state/key dflipfloplw cell: sel=1 selects D1 (external
//  plaintext/key shares), sel=0 selects D0 (round feedback).
//  Also generates the round counter for the key schedule and the capture/last-round/done strobes.
//  Sits directly upstream of the state and key register arrays.
// PARAMETERS
//  ROUNDS    31  number of full rounds before final key addition
//  SBOX_LAT  2   cycles per round through the pipelined shared S-box; must be >= 1
//  CNT_W     5   width of round_cnt; must be >= clog2(ROUNDS+1)
//  LAT_W     2   width of internal latency counter; must be >= clog2(SBOX_LAT), min 1
// PORTS
//  clk         in   1      rising-edge clock, single domain
//  rst_n       in   1      synchronous reset, active low
//  start       in   1      request new encryption; sampled only in IDLE
//  busy        out  1      high from LOAD through FIN inclusive
//  sel_load    out  1      to sel of state/key flops; 1 only in LOAD cycle
//  round_en    out  1      1-cycle strobe: S-box output valid, round result captured
//  round_cnt   out  CNT_W  current round index for key-schedule counter XOR (1..ROUNDS)
//  last_round  out  1      high in FIN: state holds output of round ROUNDS, apply K(ROUNDS+1)
//  done        out  1      1-cycle pulse, coincident with last_round; ciphertext valid
// BEHAVIOUR
//  Clock and reset: one clock, clk. Reset is synchronous and active-low (rst_n).
//  States: IDLE, LOAD, RUN, FIN (binary-encoded, registered).
//  Reset: rst_n=0 at a clk edge forces state=IDLE, lat_cnt=0 and round_cnt=0.
//   All outputs then read 0 (busy, sel_load, round_en, last_round, done all 0).
//  Reset mid-operation: abort immediately to IDLE; no done pulse is issued.
//  IDLE:  start=1 -> LOAD; else stay. Outputs 0, round_cnt=0.
//  LOAD:  exactly 1 cycle. sel_load=1, busy=1, round_cnt=1. -> RUN with lat_cnt=0.
//  RUN:   sel_load=0, busy=1. lat_cnt increments 0..SBOX_LAT-1.
//   round_en=1 when lat_cnt==SBOX_LAT-1.
//   On that cycle: if round_cnt==ROUNDS -> FIN; else round_cnt+1 and lat_cnt wraps to 0.
//  FIN:   1 cycle. last_round=1, done=1, busy=1, round_cnt holds ROUNDS. -> IDLE.
//  Outputs are combinational decode of registered state/counters only.
//   No path from start to any output in the same cycle.
//  Timing: let t be the cycle in which start=1 is sampled in IDLE.
//   LOAD is at t+1.
//   round_en pulses at t+1+k*SBOX_LAT for k=1..ROUNDS.
//   FIN/done is at t+2+ROUNDS*SBOX_LAT (t+64 with defaults).
//   Back-to-back: start high in FIN is ignored. The earliest accepted start is
//   in the IDLE cycle t+3+ROUNDS*SBOX_LAT.
//  start while busy: ignored, never queued. A start level held high restarts on each
//   IDLE visit.
//  SBOX_LAT=1: round_en is high every RUN cycle; lat_cnt stays 0.
//  Counter widths: round_cnt and lat_cnt never exceed ROUNDS and SBOX_LAT-1; no wrap
//   beyond these. Elaboration fails (generate-time $error) if a width parameter is too small.
// STRUCTURE
//  Shared include present_defs.vh: state encodings ST_IDLE/ST_LOAD/ST_RUN/ST_FIN,
//   PRESENT_ROUNDS=31, default SBOX_LAT.
//   The core top, key schedule and this block all use it.
//  One sub-module: present_lat_ctr. Modulo-SBOX_LAT counter with clear, enable and a
//   terminal-count output. Used for lat_cnt.
//  FSM and round counter are in this module.
// TESTING
//  1 Reset: rst_n=0 for 3 cycles with start=1 -> all outputs 0, stays IDLE while rst_n=0.
//  2 Nominal (defaults): start pulse at t -> sel_load=1 only at t+1.
//    Exactly 31 round_en pulses at t+3, t+5, .., t+63 with round_cnt=1..31 on them.
//    done=last_round=1 only at t+64.
//  3 Mid-run reset: rst_n=0 at t+20 -> IDLE next cycle, round_cnt=0, no done.
//    Restart then yields a full 64-cycle run.
//  4 start ignored: start held high t..t+70 -> exactly one extra run, accepted at t+65.
//    No pulse starts a run while busy=1.
//  5 SBOX_LAT=1, ROUNDS=3 build: round_en at t+2, t+3, t+4 with round_cnt 1, 2, 3.
//    done at t+5.
//  6 Integration with dflipfloplw array: load plaintext 0x0 and key 0x0 (shares
//    recombined) -> ciphertext 0x5579C1387B228445.

Source files
------------

// File: rtl/present_round_ctrl_pkg.sv
// Shared definitions for the PRESENT round controller: FSM state encoding,
// default round/latency values and a width helper.
package present_round_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StRun  = 2'd2,
        StFin  = 2'd3
    } state_e;

    localparam int unsigned PresentRounds  = 31;
    localparam int unsigned DefaultSboxLat = 2;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int unsigned min_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/present_round_ctrl_if.sv
// Handshake/strobe bundle between the round controller and the state/key
// register arrays. master = requester driving start, slave = controller.
interface present_round_ctrl_if #(
    parameter int unsigned CNT_W = 5
);
    logic             start;
    logic             busy;
    logic             sel_load;
    logic             round_en;
    logic [CNT_W-1:0] round_cnt;
    logic             last_round;
    logic             done;

    modport master (
        output start,
        input  busy, sel_load, round_en, round_cnt, last_round, done
    );

    modport slave (
        input  start,
        output busy, sel_load, round_en, round_cnt, last_round, done
    );
endinterface

// File: rtl/present_lat_ctr.sv
// Modulo-SBOX_LAT counter tracking cycles spent inside one round of the
// pipelined shared S-box. tc flags the cycle the S-box output is valid.
module present_lat_ctr
    import present_round_ctrl_pkg::*;
#(
    parameter int unsigned SBOX_LAT = DefaultSboxLat,
    parameter int unsigned LAT_W    = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    if (SBOX_LAT < 1) begin : g_lat_chk
        $error("present_lat_ctr: SBOX_LAT must be >= 1");
    end
    if (LAT_W < min_width(SBOX_LAT)) begin : g_width_chk
        $error("present_lat_ctr: LAT_W too small for SBOX_LAT");
    end

    localparam logic [LAT_W-1:0] LastCnt = LAT_W'(SBOX_LAT - 1);

    logic [LAT_W-1:0] cnt_q;

    assign tc = (cnt_q == LastCnt);

    // Count 0..SBOX_LAT-1 while enabled, wrapping on terminal count.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= tc ? '0 : cnt_q + LAT_W'(1);
        end
    end

endmodule

// File: rtl/present_round_ctrl.sv
// Round controller for the masked PRESENT core: sequences load, ROUNDS
// S-box rounds and the final key addition, and drives the sel line of the
// state/key flop arrays (1 = external shares, 0 = round feedback).
module present_round_ctrl
    import present_round_ctrl_pkg::*;
#(
    parameter int unsigned ROUNDS   = PresentRounds,
    parameter int unsigned SBOX_LAT = DefaultSboxLat,
    parameter int unsigned CNT_W    = 5,
    parameter int unsigned LAT_W    = 2
) (
    input logic                 clk,
    input logic                 rst_n,
    present_round_ctrl_if.slave bus
);

    if (CNT_W < $clog2(ROUNDS + 1)) begin : g_cnt_chk
        $error("present_round_ctrl: CNT_W too small for ROUNDS");
    end

    localparam logic [CNT_W-1:0] LastRound = CNT_W'(ROUNDS);

    state_e           state_q;
    logic [CNT_W-1:0] round_q;
    logic             in_run;
    logic             lat_clr;
    logic             lat_tc;

    assign in_run  = (state_q == StRun);
    assign lat_clr = !in_run;

    present_lat_ctr #(
        .SBOX_LAT (SBOX_LAT),
        .LAT_W    (LAT_W)
    ) u_lat_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (lat_clr),
        .en    (in_run),
        .tc    (lat_tc)
    );

    // FSM and round counter; round_cnt is 1 from LOAD onwards and holds
    // ROUNDS through FIN, returning to 0 only on re-entry to IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            round_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        state_q <= StLoad;
                        round_q <= CNT_W'(1);
                    end
                end
                StLoad: begin
                    state_q <= StRun;
                end
                StRun: begin
                    if (lat_tc) begin
                        if (round_q == LastRound) begin
                            state_q <= StFin;
                        end else begin
                            round_q <= round_q + CNT_W'(1);
                        end
                    end
                end
                StFin: begin
                    state_q <= StIdle;
                    round_q <= '0;
                end
                default: begin
                    state_q <= StIdle;
                    round_q <= '0;
                end
            endcase
        end
    end

    // Outputs decode registered state only, so start never reaches them combinationally.
    assign bus.busy       = (state_q != StIdle);
    assign bus.sel_load   = (state_q == StLoad);
    assign bus.round_en   = in_run && lat_tc;
    assign bus.round_cnt  = round_q;
    assign bus.last_round = (state_q == StFin);
    assign bus.done       = (state_q == StFin);

endmodule

// File: tb/tb_present_round_ctrl.sv
// Directed bench for present_round_ctrl: default build (31 rounds, 2-cycle
// S-box) plus a 3-round, 1-cycle S-box build sharing the same clock/reset.
module tb_present_round_ctrl;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    present_round_ctrl_if #(.CNT_W(5)) bus_a ();
    present_round_ctrl_if #(.CNT_W(2)) bus_b ();

    present_round_ctrl #(
        .ROUNDS   (31),
        .SBOX_LAT (2),
        .CNT_W    (5),
        .LAT_W    (2)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    present_round_ctrl #(
        .ROUNDS   (3),
        .SBOX_LAT (1),
        .CNT_W    (2),
        .LAT_W    (1)
    ) u_dut_small (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected {busy, sel_load, round_en, last_round, done, round_cnt[7:0]} at
    // cycle offset o from the cycle start was sampled, for r rounds of l cycles.
    function automatic logic [12:0] expect_at(input int o, input int r, input int l);
        logic busy, sel, ren, fin;
        int   cnt;
        busy = 1'b0; sel = 1'b0; ren = 1'b0; fin = 1'b0; cnt = 0;
        if (o == 1) begin
            busy = 1'b1; sel = 1'b1; cnt = 1;
        end else if (o >= 2 && o <= 1 + r * l) begin
            busy = 1'b1;
            cnt  = (o - 2) / l + 1;
            ren  = ((o - 1) % l == 0);
        end else if (o == 2 + r * l) begin
            busy = 1'b1; fin = 1'b1; cnt = r;
        end
        return {busy, sel, ren, fin, fin, 8'(cnt)};
    endfunction

    function automatic logic [12:0] obs_a();
        return {bus_a.busy, bus_a.sel_load, bus_a.round_en, bus_a.last_round, bus_a.done,
                8'(bus_a.round_cnt)};
    endfunction

    function automatic logic [12:0] obs_b();
        return {bus_b.busy, bus_b.sel_load, bus_b.round_en, bus_b.last_round, bus_b.done,
                8'(bus_b.round_cnt)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One start pulse on the default build, checked every cycle through return to IDLE.
    task automatic run_full(input string tag);
        int n_ren;
        n_ren = 0;
        bus_a.start = 1'b1;
        for (int o = 0; o <= 66; o++) begin
            if (o > 0) step();
            if (o == 1) bus_a.start = 1'b0;
            check_eq($sformatf("%s_o%0d", tag, o), obs_a(), expect_at(o, 31, 2));
            if (bus_a.round_en) n_ren++;
        end
        check_eq($sformatf("%s_ren_count", tag), n_ren, 31);
    endtask

    initial begin
        int n_ren;
        int n_load;

        // Reset held with start high: everything stays idle.
        rst_n       = 1'b0;
        bus_a.start = 1'b1;
        bus_b.start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq($sformatf("reset_a_%0d", i), obs_a(), 13'h0);
            check_eq($sformatf("reset_b_%0d", i), obs_b(), 13'h0);
        end
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
        rst_n       = 1'b1;
        step();
        check_eq("idle_after_reset", obs_a(), 13'h0);

        // Nominal run.
        run_full("nom");

        // Mid-run reset at offset 20: idle next cycle, no done afterwards.
        step();
        bus_a.start = 1'b1;
        for (int o = 0; o <= 21; o++) begin
            if (o > 0) step();
            if (o == 1) bus_a.start = 1'b0;
            if (o == 21) begin
                check_eq("midrst_o21", obs_a(), 13'h0);
            end else begin
                check_eq($sformatf("midrst_o%0d", o), obs_a(), expect_at(o, 31, 2));
            end
            if (o == 20) rst_n = 1'b0;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq($sformatf("midrst_idle_%0d", i), obs_a(), 13'h0);
        end
        run_full("restart");

        // start held high t..t+70: second run accepted at t+65, no third.
        step();
        n_load = 0;
        bus_a.start = 1'b1;
        for (int o = 0; o <= 140; o++) begin
            if (o > 0) step();
            if (o == 71) bus_a.start = 1'b0;
            check_eq($sformatf("hold_o%0d", o), obs_a(),
                     (o < 65) ? expect_at(o, 31, 2) : expect_at(o - 65, 31, 2));
            if (bus_a.sel_load) n_load++;
        end
        check_eq("hold_load_count", n_load, 2);

        // Three rounds, single-cycle S-box.
        step();
        n_ren = 0;
        bus_b.start = 1'b1;
        for (int o = 0; o <= 7; o++) begin
            if (o > 0) step();
            if (o == 1) bus_b.start = 1'b0;
            check_eq($sformatf("lat1_o%0d", o), obs_b(), expect_at(o, 3, 1));
            if (bus_b.round_en) n_ren++;
        end
        check_eq("lat1_ren_count", n_ren, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
